// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the CPU request port and a byte-masked
// single-port data memory. Decodes RISC-V funct3 widths, generates lane
// masks and replicated store data, aligns and extends load data, and flags
// misaligned or illegal requests without touching memory.
module mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rstrb_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;

  logic        req_legal;
  logic        req_aligned;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign req_ready_o = (state == IDLE);

  // Decode legality, alignment, store lane mask and replicated store data
  // straight from the incoming request so they can be registered on accept.
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b0;
    case (req_funct3_i)
      3'b000: begin
        req_legal   = 1'b1;
        req_aligned = 1'b1;
      end
      3'b001: begin
        req_legal   = 1'b1;
        req_aligned = ~req_addr_i[0];
      end
      3'b010: begin
        req_legal   = 1'b1;
        req_aligned = (req_addr_i[1:0] == 2'b00);
      end
      3'b100: begin
        req_legal   = ~req_we_i;
        req_aligned = 1'b1;
      end
      3'b101: begin
        req_legal   = ~req_we_i;
        req_aligned = ~req_addr_i[0];
      end
      default: begin
        req_legal   = 1'b0;
        req_aligned = 1'b0;
      end
    endcase

    st_mask = 4'b1111;
    st_data = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        st_mask = 4'b0001 << req_addr_i[1:0];
        st_data = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << req_addr_i[1:0];
        st_data = {2{req_wdata_i[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = req_wdata_i;
      end
    endcase
  end

  // Shift the addressed byte/halfword down to bit 0 and extend per funct3.
  always_comb begin
    ld_shift = mem_rdata_i >> {lat_off, 3'b000};
    case (lat_f3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h000000, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0000, ld_shift[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Request FSM with registered memory-side and response outputs; strobe,
  // mask and response valid default low so each is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_f3      <= '0;
      lat_off     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      mem_addr_o  <= '0;
      mem_rstrb_o <= 1'b0;
      mem_wmask_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_rstrb_o <= 1'b0;
      mem_wmask_o <= '0;
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            lat_we     <= req_we_i;
            lat_f3     <= req_funct3_i;
            lat_off    <= req_addr_i[1:0];
            mem_addr_o <= req_addr_i;
            if (req_legal && req_aligned) begin
              state <= ACCESS;
              if (req_we_i) begin
                mem_wmask_o <= st_mask;
                mem_wdata_o <= st_data;
              end else begin
                mem_rstrb_o <= 1'b1;
              end
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end
          end
        end
        ACCESS: begin
          if (lat_we) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= ld_data;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a byte-array
// reference model, with a simple word memory attached to the memory port.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_addr_o;
  logic        mem_rstrb_o;
  logic [31:0] mem_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [7:0]  ref_mem [64];

  mem_lsu #(.ADDR_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mem_addr_o(mem_addr_o),
    .mem_rstrb_o(mem_rstrb_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_wmask_o(mem_wmask_o),
    .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  // Byte-masked memory: read data appears the cycle after the strobe edge.
  always @(posedge clk) begin
    if (mem_rstrb_o) mem_rdata_i <= mem[mem_addr_o[5:2]];
    for (int j = 0; j < 4; j++)
      if (mem_wmask_o[j]) mem[mem_addr_o[5:2]][8*j +: 8] <= mem_wdata_o[8*j +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  // Assemble little-endian bytes from the reference array and extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[(addr + k) % 64];
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // Issue one request at a negedge where the DUT is idle, follow it to its
  // response, and check memory-side activity, latency and response fields.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n, strobes, masks, sz, exp_lat;
    bit done, exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata, exp_rdata;
    exp_err = is_err(we, f3, addr);
    sz = size_of(f3);
    exp_mask = '0;
    for (int k = 0; k < sz; k++) exp_mask[(addr % 4) + k] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wdata[8*(j % sz) +: 8];
    exp_rdata = (exp_err || we) ? 32'h0 : ref_load(f3, addr);
    exp_lat = exp_err ? 1 : (we ? 2 : 3);
    rdata = '0;
    err = 1'b0;
    check("ready_idle", {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk);
    n = 0; done = 0; strobes = 0; masks = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
      if (mem_rstrb_o) begin
        strobes++;
        check("rd_addr", mem_addr_o, addr);
      end
      if (mem_wmask_o != 4'h0) begin
        masks++;
        check("wmask", {28'h0, mem_wmask_o}, {28'h0, exp_mask});
        check("wdata", mem_wdata_o, exp_wdata);
        check("wr_addr", mem_addr_o, addr);
      end
      if (rsp_valid_o) begin
        done = 1;
        rdata = rsp_rdata_o;
        err = rsp_err_o;
        req_valid_i = 1'b0;
      end else begin
        check("ready_busy", {31'h0, req_ready_o}, 32'h0);
        req_valid_i = 1'($urandom_range(0, 1));
        req_we_i = 1'($urandom_range(0, 1));
        req_funct3_i = 3'($urandom_range(0, 7));
        req_addr_i = $urandom;
        req_wdata_i = $urandom;
      end
    end
    if (!done) check("rsp_timeout", 32'h0, 32'h1);
    check("latency", n, exp_lat);
    check("rsp_err", {31'h0, err}, {31'h0, exp_err});
    check("rsp_rdata", rdata, exp_rdata);
    check("strobes", strobes, (!exp_err && !we) ? 1 : 0);
    check("masks", masks, (!exp_err && we) ? 1 : 0);
    if (!exp_err && we)
      for (int k = 0; k < sz; k++) ref_mem[(addr + k) % 64] = wdata[8*k +: 8];
    @(negedge clk);
    check("rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        w;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = mem[i][8*j +: 8];
    end
    mem_rdata_i = '0;
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst_err", {31'h0, rsp_err_o}, 32'h0);
    check("rst_rdata", rsp_rdata_o, 32'h0);
    check("rst_strobe", {31'h0, mem_rstrb_o}, 32'h0);
    check("rst_wmask", {28'h0, mem_wmask_o}, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);

    // Directed sequence with literal expectations
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    check("sw_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw_dir", rd, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, rd, er);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
    check("lb_dir", rd, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er);
    check("lbu_dir", rd, 32'h000000A5);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw_merge", rd, 32'hA5ADBEEF);
    do_req(1'b1, 3'b001, 32'h12, 32'h00008001, rd, er);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er);
    check("lh_dir", rd, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, er);
    check("lhu_dir", rd, 32'h00008001);
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, er);
    check("lw_mis_err", {31'h0, er}, 32'h1);
    do_req(1'b1, 3'b001, 32'h01, 32'h1234, rd, er);
    check("sh_mis_err", {31'h0, er}, 32'h1);
    do_req(1'b0, 3'b011, 32'h08, 32'h0, rd, er);
    check("f3_011_err", {31'h0, er}, 32'h1);
    do_req(1'b1, 3'b100, 32'h08, 32'h0, rd, er);
    check("sbu_err", {31'h0, er}, 32'h1);

    // Back-to-back loads with valid held high: one accept every 4 cycles
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h20; req_wdata_i = '0;
    for (int k = 0; k < 12; k++) begin
      check("b2b_ready", {31'h0, req_ready_o}, {31'h0, (k % 4) == 0});
      check("b2b_valid", {31'h0, rsp_valid_o}, {31'h0, (k % 4) == 3});
      if ((k % 4) == 3) check("b2b_rdata", rsp_rdata_o, ref_load(3'b010, 32'h20));
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during WAIT aborts the load without a response
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("abort_strobe", {31'h0, mem_rstrb_o}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'h0, req_ready_o}, 32'h1);
    check("abort_rdata", rsp_rdata_o, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check("abort_novalid", {31'h0, rsp_valid_o}, 32'h0);
      check("abort_nostrobe", {31'h0, mem_rstrb_o}, 32'h0);
      check("abort_nomask", {28'h0, mem_wmask_o}, 32'h0);
      @(negedge clk);
    end
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, rd, er);
    check("post_rst_sw_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd, er);
    check("post_rst_lw", rd, 32'hCAFEF00D);

    // Randomized traffic against the byte-array model
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 63));
      do_req(w, f3, a, $urandom, rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
